// File: rtl/alu_operand_sequencer.sv
// Operand fetch / writeback sequencer for the 4-bit ALU: gathers nibble operands from registers,
// memory or an immediate, captures the ALU flags and stores the result to a register or memory.
package types;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_CP  = 4'd7
    } alu_op;
endpackage

module alu_operand_sequencer
    import types::*;
#(
    parameter int ADDR_WIDTH       = 12,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  alu_op                 op,
    input  logic [1:0]            src_a_sel,
    input  logic [2:0]            src_b_sel,
    input  logic [1:0]            dst_sel,
    input  logic [3:0]            imm,
    input  logic                  writeback,
    input  logic [3:0]            reg_a,
    input  logic [3:0]            reg_b,
    input  logic [ADDR_WIDTH-1:0] reg_x,
    input  logic [ADDR_WIDTH-1:0] reg_y,
    input  logic                  flag_decimal,
    input  logic                  flag_set_en,
    input  logic                  flag_carry_set,
    input  logic                  flag_zero_set,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    input  logic [3:0]            mem_read_data,
    output logic                  mem_write_en,
    output logic [3:0]            mem_write_data,
    output logic                  reg_write_en,
    output logic                  reg_write_sel,
    output logic [3:0]            reg_write_data,
    output alu_op                 alu_op_out,
    output logic [3:0]            temp_a,
    output logic [3:0]            temp_b,
    output logic                  alu_carry_in,
    output logic                  alu_decimal_in,
    input  logic [3:0]            alu_out,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    output logic                  flag_carry,
    output logic                  flag_zero,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_WAIT_A  = 3'd2,
        S_FETCH_B = 3'd3,
        S_WAIT_B  = 3'd4,
        S_EXEC    = 3'd5,
        S_WRITE   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // The strobe is visible during the first wait cycle, so data arrives when the counter hits this.
    localparam logic [2:0] LAT = 3'(MEM_READ_LATENCY);

    state_t                  state_q, state_d;
    alu_op                   op_q, op_d;
    logic [1:0]              src_a_sel_q, src_a_sel_d;
    logic [2:0]              src_b_sel_q, src_b_sel_d;
    logic [1:0]              dst_sel_q, dst_sel_d;
    logic [3:0]              imm_q, imm_d;
    logic                    wb_q, wb_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [3:0]              temp_a_q, temp_a_d;
    logic [3:0]              temp_b_q, temp_b_d;
    logic [3:0]              result_q, result_d;
    logic                    flag_carry_q, flag_carry_d;
    logic                    flag_zero_q, flag_zero_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_read_en_q, mem_read_en_d;
    logic                    mem_write_en_q, mem_write_en_d;
    logic [3:0]              mem_write_data_q, mem_write_data_d;
    logic                    reg_write_en_q, reg_write_en_d;
    logic                    reg_write_sel_q, reg_write_sel_d;
    logic [3:0]              reg_write_data_q, reg_write_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    function automatic logic [3:0] pick_reg(input logic sel_b, input logic [3:0] a,
                                            input logic [3:0] b);
        return sel_b ? b : a;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] pick_ptr(input logic sel_y,
                                                       input logic [ADDR_WIDTH-1:0] x,
                                                       input logic [ADDR_WIDTH-1:0] y);
        return sel_y ? y : x;
    endfunction

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        src_a_sel_d      = src_a_sel_q;
        src_b_sel_d      = src_b_sel_q;
        dst_sel_d        = dst_sel_q;
        imm_d            = imm_q;
        wb_d             = wb_q;
        cnt_d            = cnt_q;
        temp_a_d         = temp_a_q;
        temp_b_d         = temp_b_q;
        result_d         = result_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        reg_write_sel_d  = reg_write_sel_q;
        reg_write_data_d = reg_write_data_q;
        mem_read_en_d    = 1'b0;
        mem_write_en_d   = 1'b0;
        reg_write_en_d   = 1'b0;
        done_d           = 1'b0;
        if (flag_set_en) begin
            flag_carry_d = flag_carry_set;
            flag_zero_d  = flag_zero_set;
        end else begin
            flag_carry_d = flag_carry_q;
            flag_zero_d  = flag_zero_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d        = op;
                    src_a_sel_d = src_a_sel;
                    src_b_sel_d = src_b_sel;
                    dst_sel_d   = dst_sel;
                    imm_d       = imm;
                    wb_d        = writeback;
                    state_d     = S_FETCH_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_A: begin
                if (src_a_sel_q[1]) begin
                    mem_addr_d    = pick_ptr(src_a_sel_q[0], reg_x, reg_y);
                    mem_read_en_d = 1'b1;
                    cnt_d         = 3'd0;
                    state_d       = S_WAIT_A;
                end else begin
                    temp_a_d = pick_reg(src_a_sel_q[0], reg_a, reg_b);
                    state_d  = S_FETCH_B;
                end
            end
            S_WAIT_A: begin
                if (cnt_q == LAT) begin
                    temp_a_d = mem_read_data;
                    state_d  = S_FETCH_B;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_FETCH_B: begin
                // Codes 4..7 all select the immediate.
                if (src_b_sel_q[2]) begin
                    temp_b_d = imm_q;
                    state_d  = S_EXEC;
                end else if (src_b_sel_q[1]) begin
                    mem_addr_d    = pick_ptr(src_b_sel_q[0], reg_x, reg_y);
                    mem_read_en_d = 1'b1;
                    cnt_d         = 3'd0;
                    state_d       = S_WAIT_B;
                end else begin
                    temp_b_d = pick_reg(src_b_sel_q[0], reg_a, reg_b);
                    state_d  = S_EXEC;
                end
            end
            S_WAIT_B: begin
                if (cnt_q == LAT) begin
                    temp_b_d = mem_read_data;
                    state_d  = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_EXEC: begin
                // ALU capture overrides any external flag load in the same cycle.
                result_d     = alu_out;
                flag_carry_d = alu_carry;
                flag_zero_d  = alu_zero;
                if (wb_q) begin
                    state_d = S_WRITE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (dst_sel_q[1]) begin
                    mem_addr_d       = pick_ptr(dst_sel_q[0], reg_x, reg_y);
                    mem_write_data_d = result_q;
                    mem_write_en_d   = 1'b1;
                end else begin
                    reg_write_sel_d  = dst_sel_q[0];
                    reg_write_data_d = result_q;
                    reg_write_en_d   = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            op_q             <= ALU_ADD;
            src_a_sel_q      <= 2'd0;
            src_b_sel_q      <= 3'd0;
            dst_sel_q        <= 2'd0;
            imm_q            <= 4'd0;
            wb_q             <= 1'b0;
            cnt_q            <= 3'd0;
            temp_a_q         <= 4'd0;
            temp_b_q         <= 4'd0;
            result_q         <= 4'd0;
            flag_carry_q     <= 1'b0;
            flag_zero_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_write_data_q <= 4'd0;
            reg_write_en_q   <= 1'b0;
            reg_write_sel_q  <= 1'b0;
            reg_write_data_q <= 4'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            src_a_sel_q      <= src_a_sel_d;
            src_b_sel_q      <= src_b_sel_d;
            dst_sel_q        <= dst_sel_d;
            imm_q            <= imm_d;
            wb_q             <= wb_d;
            cnt_q            <= cnt_d;
            temp_a_q         <= temp_a_d;
            temp_b_q         <= temp_b_d;
            result_q         <= result_d;
            flag_carry_q     <= flag_carry_d;
            flag_zero_q      <= flag_zero_d;
            mem_addr_q       <= mem_addr_d;
            mem_read_en_q    <= mem_read_en_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_write_data_q <= mem_write_data_d;
            reg_write_en_q   <= reg_write_en_d;
            reg_write_sel_q  <= reg_write_sel_d;
            reg_write_data_q <= reg_write_data_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_read_en    = mem_read_en_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_data = mem_write_data_q;
    assign reg_write_en   = reg_write_en_q;
    assign reg_write_sel  = reg_write_sel_q;
    assign reg_write_data = reg_write_data_q;
    assign alu_op_out     = op_q;
    assign temp_a         = temp_a_q;
    assign temp_b         = temp_b_q;
    assign alu_carry_in   = flag_carry_q;
    assign alu_decimal_in = flag_decimal;
    assign flag_carry     = flag_carry_q;
    assign flag_zero      = flag_zero_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
